// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_pkg : shared types and constants for the RISC-V pipeline stages   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      FETCH_WAIT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            valid;
   } if_id_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg : pipeline register with hold and flush-to-bubble controls |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_id_reg
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = rv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   input  logic            valid_i,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     instr_o,
   output logic            valid_o
);

   logic [XLEN-1:0] pc_q;
   logic [31:0]     instr_q;
   logic            valid_q;

   // Flush outranks hold so a redirect never leaves a stale instruction behind.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (!hold_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
         valid_q <= valid_i;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC, warmup/run/halt FSM, fetch-fault detection, IF/ID   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
   import rv_pkg::*;
#(
   parameter int unsigned     XLEN          = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC      = '0,
   parameter int unsigned     IMEM_DEPTH    = 64,
   parameter int unsigned     WARMUP_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic            if_id_valid,
   output logic            fault,
   output logic [XLEN-1:0] fault_pc,
   output logic            running
);

   localparam logic [XLEN:0] DEPTH_EXT = (XLEN+1)'(IMEM_DEPTH);
   localparam logic [3:0]    WARM_LAST = 4'(WARMUP_CYCLES - 1);

   fetch_state_e    state_q, state_d;
   logic [3:0]      warm_q, warm_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;
   logic            ifid_hold, ifid_flush;
   logic [XLEN:0]   pc_plus4;
   logic            redir_bad;

   // One extra bit so a wrap past 2^XLEN still reads as out of range.
   assign pc_plus4  = {1'b0, pc_q} + (XLEN+1)'(4);
   assign redir_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= DEPTH_EXT);

   always_comb begin
      state_d    = state_q;
      warm_d     = warm_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      unique case (state_q)
         FETCH_WAIT: begin
            ifid_flush = 1'b1;
            warm_d     = warm_q + 4'd1;
            if (warm_q == WARM_LAST) begin
               state_d = FETCH_RUN;
               warm_d  = '0;
            end
         end
         FETCH_RUN: begin
            if (redirect_valid) begin
               ifid_flush = 1'b1;
               if (redir_bad) begin
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_pc;
                  state_d    = FETCH_HALT;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (stall) begin
               ifid_hold = 1'b1;
            end else if (pc_plus4 < DEPTH_EXT) begin
               pc_d = pc_plus4[XLEN-1:0];
            end else begin
               // The last word still loads into IF/ID on this edge.
               fault_d    = 1'b1;
               fault_pc_d = pc_plus4[XLEN-1:0];
               state_d    = FETCH_HALT;
            end
         end
         FETCH_HALT: begin
            ifid_flush = 1'b1;
         end
         default: begin
            state_d    = FETCH_WAIT;
            ifid_flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH_WAIT;
         warm_q     <= '0;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   if_id_reg #(
      .XLEN (XLEN)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .hold_i  (ifid_hold),
      .flush_i (ifid_flush),
      .pc_i    (pc_q),
      .instr_i (imem_rdata),
      .valid_i (1'b1),
      .pc_o    (if_id_pc),
      .instr_o (if_id_instr),
      .valid_o (if_id_valid)
   );

   assign imem_addr = pc_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;
   assign running   = (state_q == FETCH_RUN);

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the hazard-aware RISC-V pipeline. It drives the instruction memory, which is byte-addressed with a combinational read, and owns the program counter. It loads the IF/ID pipeline register and applies the hazard controls from later stages: a load-use stall, and a branch/jump redirect with flush. It also detects illegal fetch targets and halts fetch on them.

## Interface
Parameters:
- XLEN, 32: address and data width.
- RESET_PC, 0: PC after reset.
- IMEM_DEPTH, 64: number of valid byte addresses in instruction memory. A fetch address must be below IMEM_DEPTH.
- WARMUP_CYCLES, 2: cycles to wait after reset before the first fetch, so that instruction memory contents are loaded. Range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-high reset.
- imem_addr, out, XLEN: fetch address. Always equals pc.
- imem_rdata, in, 32: instruction at imem_addr. Valid in the same cycle.
- stall, in, 1: hazard unit hold request for pc and IF/ID.
- redirect_valid, in, 1: taken branch or jump resolved in EX.
- redirect_pc, in, XLEN: target of the redirect.
- if_id_pc, out, XLEN: PC of the instruction held in IF/ID.
- if_id_instr, out, 32: instruction held in IF/ID.
- if_id_valid, out, 1: IF/ID holds a real instruction.
- fault, out, 1: sticky fetch-fault flag.
- fault_pc, out, XLEN: offending address.
- running, out, 1: FSM is in RUN.

## Operation
- FSM states: WAIT, RUN, HALT.
  - rst forces WAIT from any state.
  - WAIT → RUN after WARMUP_CYCLES clocks.
  - RUN → HALT on a fault.
  - HALT is exited only by rst.
- WAIT:
  - pc is held at RESET_PC.
  - IF/ID holds a bubble.
  - stall and redirect are ignored.
- Bubble definition: if_id_instr = 32'h0000_0013 (addi x0,x0,0), if_id_pc = 0, if_id_valid = 0.
- RUN, per clock, in priority order:
  1. **redirect_valid**
     - If redirect_pc[1:0] != 0 or redirect_pc >= IMEM_DEPTH: fault. pc holds, IF/ID becomes a bubble, fault_pc = redirect_pc, go to HALT.
     - Otherwise: pc <= redirect_pc and IF/ID becomes a bubble. A redirect overrides a simultaneous stall.
  2. **stall**: pc and IF/ID hold their values.
  3. **normal fetch**: IF/ID <= {pc, imem_rdata, valid = 1}, then:
     - pc <= pc + 4 if pc + 4 < IMEM_DEPTH.
     - Otherwise fault with fault_pc = pc + 4 and go to HALT. The instruction at the last word is still delivered into IF/ID in that same edge.
- HALT:
  - pc frozen.
  - After the entry edge, IF/ID shows a bubble.
  - fault = 1.
  - All inputs except rst are ignored.
- Address arithmetic: XLEN-bit unsigned. The pc + 4 comparison is done at XLEN + 1 bits, so wrap-around past 2^XLEN also counts as out of range.

## Timing
- Reset values (after any clock with rst = 1):
  - pc = RESET_PC; imem_addr = RESET_PC.
  - IF/ID = bubble.
  - fault = 0, fault_pc = 0.
  - running = 0.
  - Warmup counter = 0.
- The first edge in RUN latches the instruction at RESET_PC. WAIT therefore delays the first valid IF/ID by WARMUP_CYCLES + 1 edges after rst is released.
- Fetch latency: one edge from pc to IF/ID. Throughput is one instruction per clock while not stalled.
- Redirect sampled at edge N:
  - IF/ID is a bubble after edge N.
  - The target instruction appears in IF/ID after edge N+1.
- Stall is level-sensitive. Each stalled cycle adds one cycle of hold, with no loss of instructions.
- Reset in mid-operation takes effect at the next edge and overrides HALT, stall and redirect.
- fault is registered. It rises on the edge that enters HALT.

## Structure
- Shared package rv_pkg holds:
  - XLEN.
  - The NOP_INSTR constant (32'h0000_0013).
  - The fetch FSM state enum (WAIT / RUN / HALT).
  - The typedef if_id_t {pc, instr, valid}.
- One sub-module, if_id_reg: the IF/ID register with hold and flush inputs. It is reused later for the ID/EX pattern.
- The fetch_unit top contains the pc register, the FSM, the warmup counter and the fault logic.

## Test plan
- **Reset and warmup**: rst for 2 cycles, WARMUP_CYCLES = 2, memory contains 0x00000000, 0x403100B3, … at 0, 4, …
  - → imem_addr = 0 throughout WAIT.
  - → if_id_valid first rises on the 3rd edge after rst release, with if_id_pc = 0.
  - → The next edge gives if_id_pc = 4 and if_id_instr = 0x403100B3.
- **Stall**: in RUN at pc = 8, hold stall for 3 cycles.
  - → if_id_pc stays 4 and pc stays 8 for 3 edges.
  - → After release, if_id_pc = 8, then 12. No PC is skipped or duplicated.
- **Redirect**: at pc = 16, redirect_valid with redirect_pc = 4.
  - → Next edge: bubble (if_id_valid = 0, instr = 0x13).
  - → The following edge: if_id_pc = 4.
- **Simultaneous events**: stall = 1 and redirect_pc = 8 in the same cycle.
  - → The redirect is taken: pc = 8 and a bubble.
- **Misaligned redirect**: redirect_pc = 6.
  - → fault = 1, fault_pc = 6, running = 0, pc frozen.
  - → Later redirects and stalls have no effect.
  - → rst clears fault and returns the block to WAIT.
- **Sequential overflow**: run from 0 with no redirects, IMEM_DEPTH = 64.
  - → if_id_pc reaches 60, valid.
  - → On that same edge fault = 1 with fault_pc = 64.
  - → Afterwards IF/ID stays a bubble.
